// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes,
// FSM states, iteration bound and a conditional two's-complement helper.
package ex_muldiv_pkg;

   localparam logic [2:0] INST_MUL    = 3'b000;
   localparam logic [2:0] INST_MULH   = 3'b001;
   localparam logic [2:0] INST_MULHSU = 3'b010;
   localparam logic [2:0] INST_MULHU  = 3'b011;
   localparam logic [2:0] INST_DIV    = 3'b100;
   localparam logic [2:0] INST_DIVU   = 3'b101;
   localparam logic [2:0] INST_REM    = 3'b110;
   localparam logic [2:0] INST_REMU   = 3'b111;

   localparam logic [4:0] MD_ITER_LAST = 5'd31;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_END  = 2'd2
   } md_state_t;

   // Negates v when neg is set; doubles as absolute value and sign fix-up.
   function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Restoring radix-2 divider datapath on magnitudes: one quotient bit per step.
// The 5-bit step counter also paces the iterative multiplier in the parent.
module ex_muldiv_div_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_step,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic [31:0] o_quot,
   output logic [31:0] o_rem,
   output logic [4:0]  o_cnt
);

   logic [31:0] r_dividend;
   logic [31:0] r_divisor;
   logic [31:0] r_rem;
   logic [31:0] r_quot;
   logic [4:0]  r_cnt;

   logic [32:0] w_shifted;
   logic [31:0] w_diff;
   logic        w_ge;

   // Partial remainder stays below the divisor, so modulo-2^32 subtraction is exact.
   assign w_shifted = {r_rem, r_dividend[31]};
   assign w_ge      = w_shifted >= {1'b0, r_divisor};
   assign w_diff    = w_shifted[31:0] - r_divisor;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dividend <= '0;
         r_divisor  <= '0;
         r_rem      <= '0;
         r_quot     <= '0;
         r_cnt      <= '0;
      end else if (i_load) begin
         r_dividend <= i_dividend;
         r_divisor  <= i_divisor;
         r_rem      <= '0;
         r_quot     <= '0;
         r_cnt      <= '0;
      end else if (i_step) begin
         r_dividend <= {r_dividend[30:0], 1'b0};
         r_rem      <= w_ge ? w_diff : w_shifted[31:0];
         r_quot     <= {r_quot[30:0], w_ge};
         r_cnt      <= r_cnt + 5'd1;
      end
   end

   assign o_quot = r_quot;
   assign o_rem  = r_rem;
   assign o_cnt  = r_cnt;

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M multiply/divide unit for the execute stage.
// MULDIV_FAST_MUL_EN: single-cycle multiplier instead of 32-step shift-add.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [2:0]      funct3_i,
   input  logic [4:0]      reg_waddr_i,
   output logic            hold_req_o,
   output logic            ready_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      reg_waddr_o,
   output logic            busy_o
);

   md_state_t   r_state;
   logic [2:0]  r_funct3;
   logic [4:0]  r_rd;
   logic        r_special;
   logic        r_neg_res;
   logic        r_neg_rem;
   logic [31:0] r_spec_res;
   logic [31:0] r_mplier;
   logic [63:0] r_acc;
   logic [63:0] r_mcand;

   logic        w_start, w_is_div, w_s1, w_s2, w_neg1, w_neg2;
   logic        w_div0, w_ovf, w_special, w_to_end, w_neg_res;
   logic [31:0] w_abs1, w_abs2, w_spec_res;
   logic [31:0] w_quot_raw, w_rem_raw, w_quot, w_rem, w_result;
   logic [63:0] w_acc_init, w_prod;
   logic [4:0]  w_cnt;

   assign w_start  = (r_state == MD_IDLE) & start_i & ~kill_i;
   assign w_is_div = funct3_i[2];
   assign w_s1 = (funct3_i == INST_MULH) | (funct3_i == INST_MULHSU) |
                 (funct3_i == INST_DIV)  | (funct3_i == INST_REM);
   assign w_s2 = (funct3_i == INST_MULH) | (funct3_i == INST_DIV) | (funct3_i == INST_REM);
   assign w_neg1 = w_s1 & op1_i[31];
   assign w_neg2 = w_s2 & op2_i[31];
   assign w_abs1 = mag(op1_i, w_neg1);
   assign w_abs2 = mag(op2_i, w_neg2);

   assign w_div0     = w_is_div & (op2_i == '0);
   assign w_ovf      = w_is_div & ~funct3_i[0] & (op1_i == 32'h8000_0000) & (op2_i == '1);
   assign w_special  = w_div0 | w_ovf;
   assign w_spec_res = w_div0 ? (funct3_i[1] ? op1_i : 32'hFFFF_FFFF)
                              : (funct3_i[1] ? 32'h0 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] w_fop1, w_fop2;
   // Sign-extended 33-bit operands; the low 64 product bits are all MUL* needs.
   assign w_fop1     = {{32{w_neg1}}, op1_i};
   assign w_fop2     = {{32{w_neg2}}, op2_i};
   assign w_acc_init = w_fop1 * w_fop2;
   assign w_to_end   = w_special | ~w_is_div;
   assign w_neg_res  = w_is_div & (w_neg1 ^ w_neg2);
`else
   assign w_acc_init = '0;
   assign w_to_end   = w_special;
   assign w_neg_res  = w_neg1 ^ w_neg2;
`endif

   ex_muldiv_div_iter u_div_iter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_start),
      .i_step     (r_state == MD_CALC),
      .i_dividend (w_abs1),
      .i_divisor  (w_abs2),
      .o_quot     (w_quot_raw),
      .o_rem      (w_rem_raw),
      .o_cnt      (w_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= MD_IDLE;
         r_funct3   <= '0;
         r_rd       <= '0;
         r_special  <= 1'b0;
         r_neg_res  <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_spec_res <= '0;
         r_mplier   <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
      end else if (kill_i) begin
         r_state <= MD_IDLE;
      end else begin
         case (r_state)
            MD_IDLE: if (w_start) begin
               r_funct3   <= funct3_i;
               r_rd       <= reg_waddr_i;
               r_special  <= w_special;
               r_spec_res <= w_spec_res;
               r_neg_res  <= w_neg_res;
               r_neg_rem  <= w_neg1;
               r_acc      <= w_acc_init;
               r_mcand    <= {32'd0, w_abs1};
               r_mplier   <= w_abs2;
               r_state    <= w_to_end ? MD_END : MD_CALC;
            end
            MD_CALC: begin
               if (r_mplier[0]) r_acc <= r_acc + r_mcand;
               r_mcand  <= {r_mcand[62:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[31:1]};
               if (w_cnt == MD_ITER_LAST) r_state <= MD_END;
            end
            MD_END:  r_state <= MD_IDLE;
            default: r_state <= MD_IDLE;
         endcase
      end
   end

   // Sign fix-up happens on the settled datapath while in END.
   assign w_prod = r_neg_res ? (~r_acc + 64'd1) : r_acc;
   assign w_quot = mag(w_quot_raw, r_neg_res);
   assign w_rem  = mag(w_rem_raw, r_neg_rem);

   always_comb begin
      w_result = '0;
      if (r_special) begin
         w_result = r_spec_res;
      end else begin
         case (r_funct3)
            INST_MUL:                          w_result = w_prod[31:0];
            INST_MULH, INST_MULHSU, INST_MULHU: w_result = w_prod[63:32];
            INST_DIV, INST_DIVU:               w_result = w_quot;
            default:                           w_result = w_rem;
         endcase
      end
   end

   assign ready_o     = (r_state == MD_END);
   assign result_o    = ready_o ? w_result : '0;
   assign reg_waddr_o = ready_o ? r_rd : '0;
   assign busy_o      = (r_state != MD_IDLE);
   assign hold_req_o  = w_start | (r_state == MD_CALC);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed table, kill/reset sequences and
// random operations against an arithmetic reference model.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i, kill_i;
   logic [31:0] op1_i, op2_i;
   logic [2:0]  funct3_i;
   logic [4:0]  reg_waddr_i;
   logic        hold_req_o, ready_o, busy_o;
   logic [31:0] result_o;
   logic [4:0]  reg_waddr_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_muldiv #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .kill_i      (kill_i),
      .op1_i       (op1_i),
      .op2_i       (op2_i),
      .funct3_i    (funct3_i),
      .reg_waddr_i (reg_waddr_i),
      .hold_req_o  (hold_req_o),
      .ready_o     (ready_o),
      .result_o    (result_o),
      .reg_waddr_o (reg_waddr_o),
      .busy_o      (busy_o)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa, sb, ubs, sp;
      longint unsigned ua, ub, up;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ubs = {32'd0, b};
      case (f3)
         3'd0: begin up = ua * ub; return up[31:0]; end
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * ubs; return sp[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; sp = sa / sb; return sp[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; up = ua / ub; return up[31:0]; end
         3'd6: begin if (b == 0) return a; sp = sa % sb; return sp[31:0]; end
         default: begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return MUL_LAT;
      if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
   endfunction

   // Entered at the start of cycle T (just after a rising edge); leaves two cycles after END.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                         input bit poke);
      int          lat;
      bit          got, hold_bad;
      logic [31:0] res;
      logic [4:0]  wa;
      logic        hold_end;
      start_i = 1'b1; funct3_i = f3; op1_i = a; op2_i = b; reg_waddr_i = rd;
      @(negedge clk);
      chk("hold_start", 32'(hold_req_o), 32'd1);
      got = 0; hold_bad = 0; lat = 0; res = '0; wa = '0; hold_end = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(posedge clk); #1;
         start_i     = poke && exp_lat > 25 && (c == 3 || c == 20);
         funct3_i    = 3'($urandom);
         op1_i       = $urandom;
         op2_i       = $urandom;
         reg_waddr_i = 5'($urandom);
         @(negedge clk);
         if (ready_o) begin
            got = 1; lat = c; res = result_o; wa = reg_waddr_o; hold_end = hold_req_o;
         end else if (!hold_req_o) begin
            hold_bad = 1;
         end
      end
      start_i = 1'b0;
      chk("ready_seen", 32'(got), 32'd1);
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("result", res, exp_res);
      chk("waddr", 32'(wa), 32'(rd));
      chk("hold_in_end", 32'(hold_end), 32'd0);
      chk("hold_during_calc", 32'(hold_bad), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ready_one_cycle", 32'(ready_o), 32'd0);
      chk("result_zero_idle", result_o, 32'd0);
      chk("busy_after_end", 32'(busy_o), 32'd0);
      $display("op f3=%0d a=%h b=%h rd=%0d res=%h exp=%h lat=%0d exp_lat=%0d",
               f3, a, b, rd, res, exp_res, lat, exp_lat);
      @(posedge clk); #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_hold"},  32'(hold_req_o),  32'd0);
      chk({tag, "_ready"}, 32'(ready_o),     32'd0);
      chk({tag, "_result"}, result_o,        32'd0);
      chk({tag, "_waddr"}, 32'(reg_waddr_o), 32'd0);
      chk({tag, "_busy"},  32'(busy_o),      32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   vec_t vt[12];

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      bit          seen;

      vt[0]  = '{INST_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
      vt[1]  = '{INST_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
      vt[2]  = '{INST_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1};
      vt[3]  = '{INST_REMU,   32'd100,       32'd0,         32'd100,       1};
      vt[4]  = '{INST_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vt[5]  = '{INST_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
      vt[6]  = '{INST_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
      vt[7]  = '{INST_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
      vt[8]  = '{INST_MUL,    32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFF1, MUL_LAT};
      vt[9]  = '{INST_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
      vt[10] = '{INST_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
      vt[11] = '{INST_REM,    32'd17,        32'hFFFF_FFFB, 32'd2,         33};

      rst = 1'b1; start_i = 1'b0; kill_i = 1'b0;
      op1_i = '0; op2_i = '0; funct3_i = '0; reg_waddr_i = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("reset");
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++)
         run_op(vt[i].f3, vt[i].a, vt[i].b, 5'(i + 1), vt[i].exp, vt[i].lat, 1'b0);

      // kill in the same cycle as start: nothing is accepted
      start_i = 1'b1; kill_i = 1'b1; funct3_i = INST_DIV; op1_i = 32'd50; op2_i = 32'd5;
      @(negedge clk);
      chk("kill_start_hold", 32'(hold_req_o), 32'd0);
      @(posedge clk); #1;
      start_i = 1'b0; kill_i = 1'b0;
      @(negedge clk);
      chk("kill_start_busy", 32'(busy_o), 32'd0);
      $display("seq kill_with_start busy=%0d", busy_o);
      @(posedge clk); #1;

      // kill at T+10 of a DIV, fresh start at T+12
      start_i = 1'b1; funct3_i = INST_DIV; op1_i = 32'd1000; op2_i = 32'd3; reg_waddr_i = 5'd9;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
      end
      kill_i = 1'b1;
      @(negedge clk);
      chk("kill_busy_before", 32'(busy_o), 32'd1);
      @(posedge clk); #1;
      kill_i = 1'b0;
      @(negedge clk);
      chk("kill_busy_after", 32'(busy_o), 32'd0);
      chk("kill_ready", 32'(ready_o), 32'd0);
      $display("seq kill_mid_div busy=%0d ready=%0d", busy_o, ready_o);
      @(posedge clk); #1;
      run_op(INST_DIV, 32'd1000, 32'd3, 5'd6, 32'd333, 33, 1'b0);

      // reset at T+5 of a DIVU
      start_i = 1'b1; funct3_i = INST_DIVU; op1_i = 32'd1000; op2_i = 32'd7; reg_waddr_i = 5'd3;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("midrst");
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (ready_o) seen = 1;
      end
      chk("midrst_no_ready", 32'(seen), 32'd0);
      $display("seq reset_mid_divu ready_seen=%0d", seen);
      @(posedge clk); #1;

      // start_i pulses while busy must be ignored
      run_op(INST_DIVU, 32'd1000, 32'd7, 5'd12, 32'd142, 33, 1'b1);
      run_op(INST_MULHU, 32'hDEAD_BEEF, 32'h1234_5678,
             5'd13, ref_md(INST_MULHU, 32'hDEAD_BEEF, 32'h1234_5678), MUL_LAT, 1'b1);

      for (int i = 0; i < 30; i++) begin
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: a = 32'd0;
            1: a = 32'h8000_0000;
            2: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 15));
            3: b = 32'h8000_0000;
            default: b = $urandom;
         endcase
         run_op(f3, a, b, 5'($urandom), ref_md(f3, a, b), ref_lat(f3, a, b),
                $urandom_range(0, 3) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It takes the registered operands, funct3 and destination register of an M-extension instruction and computes the result over several cycles. While it runs, it raises a hold request so the pipeline stalls. It presents the result with a one-cycle write-back strobe for EX to forward to the register file.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset; all state cleared on the rising edge where rst=1.
- start_i  in  1  EX decodes an OP with funct7=0000001 in the current cycle.
- kill_i  in  1  flush from jump/interrupt; aborts any operation.
- op1_i  in  XLEN  rs1 value (from ID/EX reg1_rdata).
- op2_i  in  XLEN  rs2 value (from ID/EX reg2_rdata).
- funct3_i  in  3  M-op select.
- reg_waddr_i  in  5  rd.
- hold_req_o  out  1  stall request to ctrl; ctrl maps it to hold level `Hold_Id`.
- ready_o  out  1  one-cycle pulse: result_o valid, write rd.
- result_o  out  XLEN  result; 0 when ready_o=0.
- reg_waddr_o  out  5  latched rd; 0 when ready_o=0.
- busy_o  out  1  state != IDLE.

## Operation
- funct3 encoding:
  - 000 MUL low 32 bits.
  - 001 MULH signed×signed high.
  - 010 MULHSU signed×unsigned high.
  - 011 MULHU unsigned high.
  - 100 DIV.
  - 101 DIVU.
  - 110 REM.
  - 111 REMU.
- States:
  - IDLE → CALC on start_i & ~kill_i when the op is non-special.
  - IDLE → END on start_i & ~kill_i when the op is special.
  - CALC → END when the iteration counter reaches 31.
  - END → IDLE unconditionally.
- Special cases, resolved in IDLE and latched for END:
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = op1.
  - Signed overflow, op1=0x80000000 with op2=0xFFFFFFFF: DIV = 0x80000000, REM = 0.
- Division: restoring radix-2 on absolute values, 32 iterations, one quotient bit per cycle. Sign fix-up in END:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Iterative multiply: shift-add on a 64-bit accumulator, 32 iterations. Signed operands are converted to magnitude and the 64-bit product is negated on sign mismatch. MUL selects [31:0]; MULH* select [63:32].
- Operands, funct3 and rd are captured on the start edge; later input changes are ignored.
- start_i while busy_o=1 is ignored.
- kill_i in any state → IDLE at the next edge, no ready_o pulse. kill_i wins over a simultaneous start_i.
- rst mid-operation → IDLE; counter, accumulators and outputs are 0.

## Timing
- Reset values: hold_req_o=0, ready_o=0, result_o=0, reg_waddr_o=0, busy_o=0, state IDLE.
- hold_req_o = (IDLE & start_i & ~kill_i) | CALC. It is combinational, so the stall takes effect in the start cycle. It is low in END so the pipeline advances as the result is written.
- Latency, with start in cycle T:
  - Iterative ops: CALC during T+1..T+32, ready_o in T+33.
  - Special cases: ready_o in T+1.
- ready_o is high for exactly one cycle (END). The next start_i is accepted in the cycle after END.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - Multiplies use one combinational 33×33 signed multiplier.
  - Result registered; IDLE → END directly, ready_o in T+1.
  - hold_req_o is still high in cycle T.
- MULDIV_FAST_MUL_EN undefined: multiplies use the 32-cycle shift-add path, same latency as divide.
- Divide is always iterative.

## Structure
- Shared defines (defines.v): funct3 codes (`INST_MUL`…`INST_REMU`), state encodings (`MD_IDLE`, `MD_CALC`, `MD_END`), `MD_ITER_LAST` = 31.
- One sub-module, div_iter: holds the restoring-divide datapath (dividend/remainder/quotient shift registers and the 5-bit counter). The FSM, multiply and sign fix-up stay in ex_muldiv.

## Test plan
- DIV op1=-7 (0xFFFFFFF9), op2=2, start at T → hold_req_o high T..T+32; ready_o in T+33 with result 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF.
- DIVU op1=100, op2=0 → ready_o at T+1, result 0xFFFFFFFF; REMU with the same operands → 100.
- DIV op1=0x80000000, op2=0xFFFFFFFF → ready_o at T+1, result 0x80000000; REM → 0.
- MULH op1=0x80000000, op2=0x80000000 → result 0x40000000. MULHSU op1=-1, op2=0xFFFFFFFF → 0xFFFFFFFF. MUL 3×-5 → 0xFFFFFFF1.
  - With MULDIV_FAST_MUL_EN: ready_o at T+1.
  - Without MULDIV_FAST_MUL_EN: ready_o at T+33.
- kill_i at T+10 of a DIV → IDLE at T+11, busy_o=0, no ready_o through T+40; a new start at T+12 completes normally.
- rst asserted at T+5 of a DIVU → all outputs 0 at T+6; start_i asserted while busy_o=1 does not restart or corrupt the running op (result still correct at T+33).
